// File: rtl/slv_wr_pkg.sv
// Shared types and constants for the slave write controller.
package slv_wr_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StActive = 2'd1,
        StDrain  = 2'd2
    } state_e;

    localparam int unsigned DefAw = 12;
    localparam int unsigned DefDw = 32;
    localparam int unsigned DefSw = 4;

    // One FIFO entry packs {addr, data, sel, last}.
    function automatic int unsigned entry_width(input int unsigned aw, input int unsigned dw,
                                                input int unsigned sw);
        return aw + dw + sw + 1;
    endfunction

    localparam int unsigned EntryW = entry_width(DefAw, DefDw, DefSw);

endpackage

// File: rtl/slv_wr_fifo.sv
// Synchronous beat FIFO with wrap-bit pointers; pushes when full and pops when empty are ignored.
module slv_wr_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] wr_data,
    input  logic             pop,
    output logic [Width-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW:0] PtrOne = 1;

    logic [PtrW:0]    wr_ptr_q;
    logic [PtrW:0]    rd_ptr_q;
    logic [Width-1:0] mem_q [Depth];
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                  (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
        do_push = push & ~full;
        do_pop  = pop & ~empty;
        rd_data = mem_q[rd_ptr_q[PtrW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/slv_wr_ctrl.sv
// Burst write slave: queues master beats and replays them as single-word memory writes.
// Optional SLV_WR_ALIGN_CHK_EN rejects beats whose byte address is not word aligned.
module slv_wr_ctrl
    import slv_wr_pkg::*;
#(
    parameter int unsigned AW    = 12,
    parameter int unsigned DW    = 32,
    parameter int unsigned SW    = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iMstWrReq,
    input  logic          iMstWrValid,
    input  logic [AW-1:0] iMstWrAddr,
    input  logic [SW-1:0] iMstWrSel,
    input  logic          iMstWrLast,
    input  logic [DW-1:0] iMstWrData,
    output logic          oMstWrReady,
    output logic          oMemWrEn,
    output logic [AW-1:0] oMemWrAddr,
    output logic [DW-1:0] oMemWrData,
    output logic [SW-1:0] oMemWrBe,
    input  logic          iMemWrRdy,
    output logic          oWrDone,
    output logic          oWrErr,
    output logic [7:0]    oBeatCnt
);

    localparam int unsigned EW = entry_width(AW, DW, SW);
    localparam logic [AW-1:0] AddrMask = {{(AW-2){1'b1}}, 2'b00};

    state_e        state_q, state_d;
    logic          fifo_full, fifo_empty;
    logic          push, pop, accept, abort, misalign;
    logic [EW-1:0] wr_entry, head;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;
    logic [SW-1:0] head_sel;
    logic          head_last;
    logic          done_q, err_q;
    logic [7:0]    cnt_q;

    assign wr_entry  = {iMstWrAddr, iMstWrData, iMstWrSel, iMstWrLast};
    assign head_addr = head[EW-1:DW+SW+1];
    assign head_data = head[DW+SW:SW+1];
    assign head_sel  = head[SW:1];
    assign head_last = head[0];

    slv_wr_fifo #(
        .Width (EW),
        .Depth (DEPTH)
    ) u_fifo (
        .clk     (iClk),
        .rst     (iRst),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge iClk) begin
        if (iRst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (iMstWrReq) state_d = StActive;
            StActive: if ((accept && iMstWrLast) || !iMstWrReq) state_d = StDrain;
            StDrain:  if (fifo_empty) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        oMstWrReady = (state_q == StActive) && !fifo_full;
        accept      = iMstWrValid && oMstWrReady;
        // A last beat accepted in the cycle req falls still completes the burst normally.
        abort       = (state_q == StActive) && !iMstWrReq && !(accept && iMstWrLast);
`ifdef SLV_WR_ALIGN_CHK_EN
        misalign    = accept && (iMstWrAddr[1:0] != 2'b00);
`else
        misalign    = 1'b0;
`endif
        push        = accept && !misalign;
        oMemWrEn    = !fifo_empty && (head_sel != '0);
        // Zero-select entries carry no write and leave the FIFO without waiting for memory.
        pop         = !fifo_empty && ((head_sel == '0) || iMemWrRdy);
        oMemWrAddr  = fifo_empty ? '0 : (head_addr & AddrMask);
        oMemWrData  = fifo_empty ? '0 : head_data;
        oMemWrBe    = fifo_empty ? '0 : head_sel;
        oWrDone     = done_q;
        oWrErr      = err_q;
        oBeatCnt    = cnt_q;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            done_q <= pop && head_last;
            err_q  <= abort || misalign;
            if (state_q == StIdle && iMstWrReq) cnt_q <= '0;
            else if (accept)                      cnt_q <= cnt_q + 8'd1;
        end
    end

endmodule

// File: doc/slv_wr_ctrl.md
SLV_WR_CTRL -- requirements
Module: slv_wr_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- AW, 12, address width
- DW, 32, data width
- SW, 4, byte-select width (DW/8)
- DEPTH, 4, beat FIFO depth (power of 2, >=2)

REQ-002 Ports SHALL be, one per line:
- iClk  in  1  single clock
- iRst  in  1  reset, synchronous, active-high
- iMstWrReq  in  1  burst request, held for whole burst
- iMstWrValid  in  1  beat valid
- iMstWrAddr  in  AW  beat byte address
- iMstWrSel  in  SW  byte selects
- iMstWrLast  in  1  final beat of burst
- iMstWrData  in  DW  beat data
- oMstWrReady  out  1  beat accept
- oMemWrEn  out  1  memory write strobe
- oMemWrAddr  out  AW  memory word address
- oMemWrData  out  DW  memory data
- oMemWrBe  out  SW  memory byte enables
- iMemWrRdy  in  1  memory accepts strobe this cycle
- oWrDone  out  1  one-cycle pulse, burst fully committed
- oWrErr  out  1  one-cycle pulse, beat/burst error
- oBeatCnt  out  8  beats accepted in current burst

Function
REQ-003 Beat handshake SHALL occur at a rising edge where iMstWrValid & oMstWrReady; no other beat is accepted.
REQ-004 oMstWrReady SHALL equal (state==ACTIVE) & !fifo_full, combinational from registered state only (no input-to-output path).
REQ-005 FSM SHALL have states IDLE, ACTIVE, DRAIN.
- IDLE->ACTIVE on iMstWrReq=1.
- ACTIVE->DRAIN on accepted beat with iMstWrLast=1.
- ACTIVE->DRAIN on iMstWrReq falling without last (abort).
- DRAIN->IDLE when FIFO empty and no write pending.
REQ-006 Accepted beats SHALL be pushed as {addr,data,sel,last} into a DEPTH-entry FIFO; the FIFO head drives oMemWr*, and oMemWrEn = !fifo_empty & (head sel != 0).
REQ-007 A head entry SHALL pop when (oMemWrEn & iMemWrRdy) or head sel==0; a zero-sel beat is silently discarded in one cycle.
REQ-008 Latency: a beat accepted at edge N into an empty FIFO SHALL show oMemWrEn=1 in the cycle after edge N.
REQ-009 Full FIFO: ready SHALL be 0; a push and pop at the same edge is only possible when not full, and occupancy is then unchanged.
REQ-010 oMemWrAddr SHALL be the beat address with bits [1:0] forced to 0.
REQ-011 oBeatCnt SHALL clear on IDLE->ACTIVE, increment per accepted beat, and wrap 255->0.
REQ-012 oWrDone SHALL pulse the cycle after the popped entry carrying last=1 leaves the FIFO.
REQ-013 Abort (REQ-005) SHALL pulse oWrErr once, still drain queued beats, and not pulse oWrDone.
REQ-014 iMstWrValid while not ACTIVE SHALL be ignored; ready stays 0.

Reset
REQ-015 On iRst=1 at an edge, the following SHALL hold from the next cycle: state=IDLE; FIFO emptied; oMstWrReady=0, oMemWrEn=0, oWrDone=0, oWrErr=0, oBeatCnt=0; oMemWrAddr/Data/Be=0.
REQ-016 Reset mid-burst SHALL discard queued beats with no further memory write.

Configuration
REQ-017 With SLV_WR_ALIGN_CHK_EN defined, a beat with addr[1:0]!=0 SHALL be accepted, not enqueued, and pulse oWrErr the next cycle; without the macro it is enqueued per REQ-010.

Structure
REQ-018 Package slv_wr_pkg SHALL hold the state enum and the FIFO entry width (AW+DW+SW+1) constant.
REQ-019 The FIFO SHALL be sub-module slv_wr_fifo, with push/pop/full/empty ports and synchronous active-high reset.

Verification
REQ-020 Single beat, addr 0x010, sel 0xF, data 0xDEADBEEF, iMemWrRdy=1 -> one oMemWrEn with addr 0x010 and be 0xF, oWrDone once, oBeatCnt=1.
REQ-021 4-beat INCR at 0x100, iMemWrRdy=0 for 10 cycles -> ready drops after 4 beats; 4 writes follow in order after release.
REQ-022 Beat with sel 0x0 mid-burst -> no oMemWrEn for that beat; other beats written; oWrDone once.
REQ-023 Req dropped after 2 of 4 beats -> oWrErr once, 2 writes, no oWrDone, return to IDLE.
REQ-024 Reset asserted with 3 beats queued -> no oMemWrEn after reset, all outputs 0, oBeatCnt=0.
REQ-025 With SLV_WR_ALIGN_CHK_EN, addr 0x102 -> oWrErr pulse, no write; without it, a write at 0x100.
